// File: rtl/demux2_buffered_if.sv
`default_nettype none
// ============================================================================
// Module      : demux2_buffered_if
// Description : Bundle of the handshake/data signals around demux2_buffered.
//               One upstream valid/ready port with a destination select, two
//               downstream valid/ready ports (A and B), and per-port
//               occupancy and delivered-word counters.
//   slave  modport : the demultiplexer's view (takes upstream, drives A/B)
//   master modport : the environment's view (offers words, consumes A/B)
// Revision    : 1.0  initial release
// ============================================================================
interface demux2_buffered_if #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             in_sel;
   logic [WIDTH-1:0] in_data;

   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] a_data;
   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] b_data;

   logic [1:0]       a_count;
   logic [1:0]       b_count;
   logic [CNTW-1:0]  a_total;
   logic [CNTW-1:0]  b_total;

   modport slave (
      input  in_valid, in_sel, in_data, a_ready, b_ready,
      output in_ready, a_valid, a_data, b_valid, b_data,
             a_count, b_count, a_total, b_total
   );

   modport master (
      output in_valid, in_sel, in_data, a_ready, b_ready,
      input  in_ready, a_valid, a_data, b_valid, b_data,
             a_count, b_count, a_total, b_total
   );
endinterface
`default_nettype wire

// File: rtl/demux2_buffered.sv
`default_nettype none
// ============================================================================
// Module      : demux2_buffered
// Description : 1-to-2 demultiplexer with an independent 2-entry FIFO per
//               output port. A word offered upstream is routed by in_sel
//               (0 = port A, 1 = port B) and appears on that port one cycle
//               later from registered storage. Each port counts its
//               delivered words, wrapping modulo 2^CNTW.
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               bus    demux2_buffered_if.slave (upstream, A, B, counters)
// Revision    : 1.0  initial release
// ============================================================================
module demux2_buffered #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 16
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   demux2_buffered_if.slave    bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } fifo_state_t;

   logic [1:0]       sel_oh;
   logic [1:0]       push;
   logic [1:0]       pop;
   logic [1:0]       port_count [2];
   logic [WIDTH-1:0] port_data  [2];
   logic [CNTW-1:0]  port_total [2];

   // Readiness depends only on the selected port's registered occupancy, so
   // a pop in the same cycle never lets a full FIFO take a word.
   assign sel_oh       = {bus.in_sel, ~bus.in_sel};
   assign bus.in_ready = bus.in_sel ? (port_count[1] != 2'd2)
                                    : (port_count[0] != 2'd2);
   assign push         = {2{bus.in_valid & bus.in_ready}} & sel_oh;
   assign pop          = {bus.b_valid & bus.b_ready, bus.a_valid & bus.a_ready};

   generate
      for (genvar i = 0; i < 2; i++) begin : g_port
         fifo_state_t      state_q, state_d;
         logic             rd_ptr_q, rd_ptr_d;
         logic             wr_ptr_q, wr_ptr_d;
         logic [CNTW-1:0]  total_q, total_d;
         logic [WIDTH-1:0] mem_q [2];

         // Ring of two slots: in state ONE the write pointer sits one past
         // the head, so a simultaneous push/pop naturally makes the new word
         // the head.
         always_comb begin
            state_d  = state_q;
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            total_d  = total_q;
            if (push[i]) begin
               wr_ptr_d = ~wr_ptr_q;
            end
            if (pop[i]) begin
               rd_ptr_d = ~rd_ptr_q;
               total_d  = total_q + CNTW'(1);
            end
            case (state_q)
               EMPTY: begin
                  if (push[i]) state_d = ONE;
               end
               ONE: begin
                  if (push[i] && !pop[i])      state_d = TWO;
                  else if (!push[i] && pop[i]) state_d = EMPTY;
               end
               TWO: begin
                  if (pop[i]) state_d = ONE;
               end
               default: state_d = EMPTY;
            endcase
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q  <= EMPTY;
               rd_ptr_q <= 1'b0;
               wr_ptr_q <= 1'b0;
               total_q  <= '0;
            end else begin
               state_q  <= state_d;
               rd_ptr_q <= rd_ptr_d;
               wr_ptr_q <= wr_ptr_d;
               total_q  <= total_d;
            end
         end

         // Storage carries no reset; stale contents are hidden by valid.
         always_ff @(posedge clk) begin
            if (push[i]) begin
               mem_q[wr_ptr_q] <= bus.in_data;
            end
         end

         assign port_count[i] = state_q;
         assign port_data[i]  = mem_q[rd_ptr_q];
         assign port_total[i] = total_q;
      end
   endgenerate

   assign bus.a_count = port_count[0];
   assign bus.b_count = port_count[1];
   assign bus.a_valid = (port_count[0] != 2'd0);
   assign bus.b_valid = (port_count[1] != 2'd0);
   assign bus.a_data  = port_data[0];
   assign bus.b_data  = port_data[1];
   assign bus.a_total = port_total[0];
   assign bus.b_total = port_total[1];

endmodule
`default_nettype wire

// File: tb/tb_demux2_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux2_buffered
// Description : Directed self-checking bench for demux2_buffered (CNTW=4 so
//               the delivered-word counter wrap is reachable quickly).
// Revision    : 1.0  initial release
// ============================================================================
module tb_demux2_buffered;

   localparam int C_WIDTH = 32;
   localparam int C_CNTW  = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   demux2_buffered_if #(.WIDTH(C_WIDTH), .CNTW(C_CNTW)) bus ();

   demux2_buffered #(.WIDTH(C_WIDTH), .CNTW(C_CNTW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic s, input logic [31:0] d,
                        input logic ar, input logic br);
      bus.in_valid = v;
      bus.in_sel   = s;
      bus.in_data  = d;
      bus.a_ready  = ar;
      bus.b_ready  = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

      // Reset values
      check("rst_a_valid",  64'(bus.a_valid), 64'd0);
      check("rst_b_valid",  64'(bus.b_valid), 64'd0);
      check("rst_a_count",  64'(bus.a_count), 64'd0);
      check("rst_b_count",  64'(bus.b_count), 64'd0);
      check("rst_totals",   64'({bus.a_total, bus.b_total}), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      tick();
      #3 rst_n = 1'b1;

      // Basic routing
      drive(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
      tick();
      check("route_a_valid", 64'(bus.a_valid), 64'd1);
      check("route_a_data",  64'(bus.a_data),  64'hDEADBEEF);
      drive(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1);
      tick();
      check("route_b_data",  64'(bus.b_data),  64'h12345678);
      check("route_a_empty", 64'(bus.a_valid), 64'd0);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      check("route_a_total", 64'(bus.a_total), 64'd1);
      check("route_b_total", 64'(bus.b_total), 64'd1);

      // Port A fill, then drain with simultaneous push/pop at count 1
      drive(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
      check("fill_rdy0", 64'(bus.in_ready), 64'd1);
      tick();
      drive(1'b1, 1'b0, 32'h2, 1'b0, 1'b0);
      check("fill_rdy1", 64'(bus.in_ready), 64'd1);
      tick();
      check("fill_count2", 64'(bus.a_count), 64'd2);
      drive(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
      check("fill_rdy_full", 64'(bus.in_ready), 64'd0);
      check("fill_head1",    64'(bus.a_data),   64'h1);
      drive(1'b1, 1'b0, 32'h3, 1'b1, 1'b0);
      check("full_pop_rdy", 64'(bus.in_ready), 64'd0);
      tick();
      check("drain_count1", 64'(bus.a_count), 64'd1);
      check("drain_head2",  64'(bus.a_data),  64'h2);
      drive(1'b1, 1'b0, 32'h3, 1'b1, 1'b0);
      check("pp_rdy", 64'(bus.in_ready), 64'd1);
      tick();
      check("pp_count", 64'(bus.a_count), 64'd1);
      check("pp_head3", 64'(bus.a_data),  64'h3);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      check("drain_empty", 64'(bus.a_count), 64'd0);
      check("drain_total", 64'(bus.a_total), 64'd4);

      // Port independence, cross push/pop, dual pop, ignored inputs
      drive(1'b1, 1'b0, 32'h10, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'hAA, 1'b0, 1'b0);
      check("ind_rdy_a_full", 64'(bus.in_ready), 64'd0);
      drive(1'b1, 1'b1, 32'hAA, 1'b0, 1'b0);
      check("ind_rdy_b", 64'(bus.in_ready), 64'd1);
      tick();
      check("ind_b_data",  64'(bus.b_data),  64'hAA);
      check("ind_a_count", 64'(bus.a_count), 64'd2);
      drive(1'b1, 1'b1, 32'hBB, 1'b1, 1'b0);
      tick();
      check("cross_a_count", 64'(bus.a_count), 64'd1);
      check("cross_a_head",  64'(bus.a_data),  64'h11);
      check("cross_b_count", 64'(bus.b_count), 64'd2);
      drive(1'b0, 1'b0, 32'hFFFF, 1'b1, 1'b1);
      tick();
      check("dual_a_count", 64'(bus.a_count), 64'd0);
      check("dual_b_count", 64'(bus.b_count), 64'd1);
      check("dual_b_head",  64'(bus.b_data),  64'hBB);
      drive(1'b0, 1'b1, 32'h5555, 1'b0, 1'b1);
      tick();
      check("ign_counts", 64'({bus.a_count, bus.b_count}), 64'd0);
      check("ind_totals", 64'({bus.a_total, bus.b_total}), 64'h63);

      // Reset mid-operation: A holds two words, B holds one
      drive(1'b1, 1'b0, 32'h51, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'h52, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 32'h61, 1'b0, 1'b0);
      tick();
      check("pre_rst_counts", 64'({bus.a_count, bus.b_count}), 64'h9);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_valid",  64'({bus.a_valid, bus.b_valid}), 64'd0);
      check("mid_rst_counts", 64'({bus.a_count, bus.b_count}), 64'd0);
      check("mid_rst_totals", 64'({bus.a_total, bus.b_total}), 64'd0);
      drive(1'b1, 1'b0, 32'h77, 1'b0, 1'b0);
      check("mid_rst_rdy", 64'(bus.in_ready), 64'd1);
      tick();
      check("in_rst_edge", 64'(bus.a_count), 64'd0);
      #3 rst_n = 1'b1;
      tick();
      check("post_rst_count", 64'(bus.a_count), 64'd1);
      check("post_rst_head",  64'(bus.a_data),  64'h77);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      check("post_rst_empty", 64'(bus.a_count), 64'd0);
      check("post_rst_total", 64'(bus.a_total), 64'd1);

      // Counter wrap: 17 words streamed through port B, 17 pops
      for (int k = 0; k < 18; k++) begin
         drive(k < 17, 1'b1, 32'h100 + 32'(k), 1'b0, 1'b1);
         tick();
         if (k < 17) begin
            check($sformatf("wrap_head%0d", k), 64'(bus.b_data), 64'h100 + 64'(k));
         end
         if (k == 16) begin
            check("wrap_total16", 64'(bus.b_total), 64'd0);
         end
      end
      check("wrap_count", 64'(bus.b_count), 64'd0);
      check("wrap_total", 64'(bus.b_total), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/demux2_buffered.md
DEMUX2_BUFFERED -- requirements
Module: demux2_buffered

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter CNTW, default 16, width of each per-port transfer counter.
REQ-003 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream word offered.
REQ-006 in_ready  output  1  block accepts the offered word this cycle.
REQ-007 in_sel  input  1  destination of the offered word: 0 routes to port A, 1 routes to port B.
REQ-008 in_data  input  WIDTH  offered word.
REQ-009 a_valid  output  1  port A head word available.
REQ-010 a_ready  input  1  port A consumer takes the head word.
REQ-011 a_data  output  WIDTH  port A head word.
REQ-012 b_valid, b_ready, b_data  same directions and widths as the A signals, for port B.
REQ-013 a_count, b_count  output  2 each  current FIFO occupancy, 0 to 2.
REQ-014 a_total, b_total  output  CNTW each  number of words delivered on the port.

Function
REQ-015 Each port SHALL own an independent 2-entry FIFO with states EMPTY(0), ONE(1) and TWO(2).
REQ-016 in_ready SHALL equal (in_sel==0 ? a_count!=2 : b_count!=2), computed combinationally from in_sel and the registered counts only.
REQ-017 A push SHALL occur when in_valid and in_ready are both high, and SHALL write in_data into the FIFO selected by in_sel.
REQ-018 A pop on port A SHALL occur when a_valid and a_ready are both high; the same rule applies to port B.
REQ-019 a_valid SHALL be high exactly when a_count is nonzero, and a_data SHALL be the oldest stored word. a_data is don't-care when a_valid is low.
REQ-020 Latency SHALL be 1 cycle: a word pushed on edge N is visible on the port outputs after edge N, with no combinational path from in_data to a_data or b_data.
REQ-021 Per-port state transitions:
- EMPTY with push goes to ONE.
- ONE with push only goes to TWO.
- ONE with pop only goes to EMPTY.
- ONE with simultaneous push and pop stays ONE, and the new word becomes the head.
- TWO with pop goes to ONE.
- Any other combination holds the state.
REQ-022 A push into a FIFO in state TWO SHALL never occur; in_ready is low in that case, even if a pop happens in the same cycle.
REQ-023 Words SHALL leave each port in the order they were pushed to that port; there is no ordering relation between port A and port B.
REQ-024 A push to one port and a pop on the other port in the same cycle SHALL both take effect.
REQ-025 Pops on A and B in the same cycle SHALL both take effect.
REQ-026 When in_valid is low, in_sel and in_data SHALL be ignored.
REQ-027 A full port SHALL NOT block traffic to the other port; in_ready for the other selection is unaffected.
REQ-028 a_total SHALL increment by 1 on each port A pop and wrap modulo 2^CNTW without saturating; b_total behaves the same for port B.
REQ-029 Stalled outputs SHALL hold: while a_valid is high and a_ready is low, a_data and a_valid SHALL remain stable; the same applies to port B.

Reset
REQ-030 While rst_n is low, regardless of clk, the block SHALL immediately force the following values:
- a_count and b_count to 0.
- a_valid and b_valid to 0.
- a_total and b_total to 0.
- FIFO pointers to their initial position.
REQ-031 Data storage SHALL NOT require a reset, and a_data and b_data are don't-care during reset.
REQ-032 Reset asserted mid-operation SHALL discard all buffered words; no pop is reported for a discarded word.
REQ-033 in_ready SHALL still follow REQ-016 during reset, evaluating as 1 because both counts are 0.
REQ-034 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Basic routing: push 0xDEADBEEF with sel=0, then 0x12345678 with sel=1, with a_ready=b_ready=1. Required response: a_data=0xDEADBEEF one cycle later, b_data=0x12345678 one cycle after that, and a_total=b_total=1.
REQ-036 Port A fill: push 0x1, 0x2, 0x3 to port A with a_ready=0. Required response: in_ready drops after the 2nd push and a_count=2. Raise a_ready and port A yields 0x1 then 0x2; the 3rd word is accepted only once a_count<2 at the start of a cycle.
REQ-037 Port independence: fill port A, then push 0xAA to port B. Required response: in_ready=1 with sel=1 while A is full, and b_data=0xAA.
REQ-038 Simultaneous push and pop: with a_count=1, push to A and pop A in the same cycle. Required response: a_count stays 1 and the head becomes the new word.
REQ-039 Counter wrap: with CNTW=4, make 17 pops on port B. Required response: b_total=1.
REQ-040 Reset mid-operation: assert rst_n=0 while a_count=2 and b_count=1, asynchronously between clock edges. Required response:
- a_valid, b_valid, both counts and both totals read 0 immediately.
- After release, a new push to A appears as the only word.
